// File: rtl/alu_if.sv
// alu_if: request/result bundle between the core scheduler and one ALU lane
interface alu_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  enable;
   logic [2:0]            core_state;
   logic [1:0]            decoded_alu_arithmetic_mux;
   logic                  decoded_alu_output_mux;
   logic [DATA_WIDTH-1:0] rs;
   logic [DATA_WIDTH-1:0] rt;
   logic [DATA_WIDTH-1:0] alu_out;
   logic                  alu_valid;
   logic                  alu_busy;
   logic                  alu_ovf;
   logic                  alu_div_by_zero;

   modport master (
      output enable, core_state, decoded_alu_arithmetic_mux, decoded_alu_output_mux, rs, rt,
      input  alu_out, alu_valid, alu_busy, alu_ovf, alu_div_by_zero
   );

   modport slave (
      input  enable, core_state, decoded_alu_arithmetic_mux, decoded_alu_output_mux, rs, rt,
      output alu_out, alu_valid, alu_busy, alu_ovf, alu_div_by_zero
   );
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle: per-lane ALU, single-cycle ADD/SUB/CMP, iterative shift-add MUL and restoring DIV
module alu_multicycle #(
   parameter int         DATA_WIDTH    = 8,
   parameter logic [2:0] EXECUTE_STATE = 3'b101
) (
   input  logic clk,
   input  logic reset,
   alu_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

   state_t         r_state, w_next;
   logic [CW-1:0]  r_cnt;
   logic [W-1:0]   r_hi, r_lo, r_b, r_out;
   logic           r_valid, r_ovf, r_dbz;
   logic           w_accept, w_last, w_is_mul, w_is_div, w_dbz, w_iter, w_ge;
   logic [1:0]     w_op;
   logic           w_cmp_sel;
   logic [W-1:0]   w_rs, w_rt, w_cmp, w_diff, w_single;
   logic [W:0]     w_add, w_sub, w_mac, w_rem;
   logic [W-1:0]   w_mul_hi, w_mul_lo, w_div_hi, w_div_lo;

   assign w_op      = bus.decoded_alu_arithmetic_mux;
   assign w_cmp_sel = bus.decoded_alu_output_mux;
   assign w_rs      = bus.rs;
   assign w_rt      = bus.rt;
   assign w_accept  = bus.enable && bus.core_state == EXECUTE_STATE && r_state == IDLE;
   assign w_is_mul  = !w_cmp_sel && w_op == 2'b10;
   assign w_is_div  = !w_cmp_sel && w_op == 2'b11;
   assign w_dbz     = w_is_div && w_rt == '0;
   assign w_iter    = w_is_mul || (w_is_div && !w_dbz);
   assign w_last    = r_cnt == CW'(W - 1);

   // bit W of the add/sub results is the carry-out / borrow
   assign w_add    = {1'b0, w_rs} + {1'b0, w_rt};
   assign w_sub    = {1'b0, w_rs} - {1'b0, w_rt};
   assign w_cmp    = {{(W-3){1'b0}}, w_rs < w_rt, w_rs == w_rt, w_rs > w_rt};
   assign w_single = w_cmp_sel ? w_cmp : w_op == 2'b00 ? w_add[W-1:0] : w_op == 2'b01 ? w_sub[W-1:0] : '1;

   // shift-add: accumulate into the high half, then shift the whole product right
   assign w_mac = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
   assign {w_mul_hi, w_mul_lo} = {w_mac, r_lo[W-1:1]};

   // restoring divide: partial remainder never exceeds the divisor, so W bits hold the difference
   assign w_rem    = {r_hi, r_lo[W-1]};
   assign w_ge     = w_rem >= {1'b0, r_b};
   assign w_diff   = w_rem[W-1:0] - r_b;
   assign w_div_hi = w_ge ? w_diff : w_rem[W-1:0];
   assign w_div_lo = {r_lo[W-2:0], w_ge};

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // next state: launch iterative ops from IDLE, return after the last iteration
   always_comb begin
      w_next = r_state;
      w_next = r_state == IDLE ? (w_accept && w_iter ? (w_is_mul ? MUL_RUN : DIV_RUN) : IDLE)
                               : (w_last ? IDLE : r_state);
   end

   // datapath: capture operands on accept, iterate while running, publish results on completion
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_b     <= '0;
         r_out   <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
         r_dbz   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_accept) begin
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= w_rs;
            r_b   <= w_rt;
            if (!w_iter) begin
               r_valid <= 1'b1;
               r_out   <= w_single;
               r_ovf   <= !w_cmp_sel && (w_op == 2'b00 ? w_add[W] : w_op == 2'b01 ? w_sub[W] : 1'b0);
               r_dbz   <= w_dbz;
            end
         end else if (r_state != IDLE) begin
            r_cnt <= r_cnt + 1'b1;
            {r_hi, r_lo} <= r_state == MUL_RUN ? {w_mul_hi, w_mul_lo} : {w_div_hi, w_div_lo};
            if (w_last) begin
               r_valid <= 1'b1;
               r_out   <= r_state == MUL_RUN ? w_mul_lo : w_div_lo;
               r_ovf   <= r_state == MUL_RUN && |w_mul_hi;
               r_dbz   <= 1'b0;
            end
         end
      end
   end

   assign bus.alu_out         = r_out;
   assign bus.alu_valid       = r_valid;
   assign bus.alu_busy        = r_state != IDLE;
   assign bus.alu_ovf         = r_ovf;
   assign bus.alu_div_by_zero = r_dbz;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: vector table plus scoreboard for 8- and 16-bit ALU lanes
module tb_alu_multicycle;
   localparam logic [2:0] EXEC = 3'b101;

   typedef struct {
      logic        w16;
      logic [1:0]  op;
      logic        cmp;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      logic        ovf;
      logic        dbz;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] y;
      logic        ovf;
      logic        dbz;
   } exp_t;

   localparam int NV = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en8 = 1'b0, en16 = 1'b0;
   logic [2:0]  core_state = EXEC;
   logic [1:0]  op = 2'b00;
   logic        cmpm = 1'b0;
   logic [31:0] rs = '0, rt = '0;
   int          errors = 0, checks = 0;
   exp_t        q8[$], q16[$];
   vec_t        tbl[NV];

   alu_if #(.DATA_WIDTH(8))  b8 ();
   alu_if #(.DATA_WIDTH(16)) b16 ();

   assign b8.enable                      = en8;
   assign b8.core_state                  = core_state;
   assign b8.decoded_alu_arithmetic_mux  = op;
   assign b8.decoded_alu_output_mux      = cmpm;
   assign b8.rs                          = rs[7:0];
   assign b8.rt                          = rt[7:0];
   assign b16.enable                     = en16;
   assign b16.core_state                 = core_state;
   assign b16.decoded_alu_arithmetic_mux = op;
   assign b16.decoded_alu_output_mux     = cmpm;
   assign b16.rs                         = rs[15:0];
   assign b16.rt                         = rt[15:0];

   alu_multicycle #(.DATA_WIDTH(8),  .EXECUTE_STATE(EXEC)) u8  (.clk(clk), .reset(reset), .bus(b8));
   alu_multicycle #(.DATA_WIDTH(16), .EXECUTE_STATE(EXEC)) u16 (.clk(clk), .reset(reset), .bus(b16));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // scoreboard: every valid pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (b8.alu_valid) begin
         if (q8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL valid8_unexpected: got valid with out=%0d, expected no valid", b8.alu_out);
         end else begin
            e = q8.pop_front();
            check("out8", {24'd0, b8.alu_out}, e.y);
            check("ovf8", {31'd0, b8.alu_ovf}, {31'd0, e.ovf});
            check("dbz8", {31'd0, b8.alu_div_by_zero}, {31'd0, e.dbz});
         end
      end
      if (b16.alu_valid) begin
         if (q16.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL valid16_unexpected: got valid with out=%0d, expected no valid", b16.alu_out);
         end else begin
            e = q16.pop_front();
            check("out16", {16'd0, b16.alu_out}, e.y);
            check("ovf16", {31'd0, b16.alu_ovf}, {31'd0, e.ovf});
            check("dbz16", {31'd0, b16.alu_div_by_zero}, {31'd0, e.dbz});
         end
      end
   end

   function automatic logic valid_of(input logic w16);
      return w16 ? b16.alu_valid : b8.alu_valid;
   endfunction

   function automatic logic busy_of(input logic w16);
      return w16 ? b16.alu_busy : b8.alu_busy;
   endfunction

   task automatic push(input vec_t v);
      exp_t e;
      e.y = v.y;
      e.ovf = v.ovf;
      e.dbz = v.dbz;
      if (v.w16) q16.push_back(e);
      else q8.push_back(e);
   endtask

   // issue one request, then measure edges from accept until valid
   task automatic run(input string name, input vec_t v);
      int n;
      @(negedge clk);
      op = v.op;
      cmpm = v.cmp;
      rs = v.a;
      rt = v.b;
      if (v.w16) en16 = 1'b1;
      else en8 = 1'b1;
      @(posedge clk);
      push(v);
      #1;
      en8 = 1'b0;
      en16 = 1'b0;
      @(negedge clk);
      n = 0;
      check({name, "_busy"}, {31'd0, busy_of(v.w16)}, {31'd0, v.lat > 0});
      while (!valid_of(v.w16) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({name, "_latency"}, n, v.lat);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int   n;
      tbl[0]  = '{0, 2'd0, 0, 10,    20,    30,    0, 0, 0};
      tbl[1]  = '{0, 2'd0, 0, 200,   100,   44,    1, 0, 0};
      tbl[2]  = '{0, 2'd0, 0, 255,   1,     0,     1, 0, 0};
      tbl[3]  = '{0, 2'd1, 0, 50,    15,    35,    0, 0, 0};
      tbl[4]  = '{0, 2'd1, 0, 3,     7,     252,   1, 0, 0};
      tbl[5]  = '{0, 2'd0, 1, 15,    10,    1,     0, 0, 0};
      tbl[6]  = '{0, 2'd1, 1, 5,     5,     2,     0, 0, 0};
      tbl[7]  = '{0, 2'd2, 1, 3,     7,     4,     0, 0, 0};
      tbl[8]  = '{0, 2'd3, 1, 7,     0,     1,     0, 0, 0};
      tbl[9]  = '{0, 2'd2, 0, 7,     6,     42,    0, 0, 8};
      tbl[10] = '{0, 2'd2, 0, 20,    20,    144,   1, 0, 8};
      tbl[11] = '{0, 2'd2, 0, 255,   255,   1,     1, 0, 8};
      tbl[12] = '{0, 2'd3, 0, 30,    5,     6,     0, 0, 8};
      tbl[13] = '{0, 2'd3, 0, 7,     0,     255,   0, 1, 0};
      tbl[14] = '{0, 2'd3, 0, 5,     9,     0,     0, 0, 8};
      tbl[15] = '{0, 2'd3, 0, 255,   1,     255,   0, 0, 8};
      tbl[16] = '{1, 2'd3, 0, 60000, 7,     8571,  0, 0, 16};
      tbl[17] = '{1, 2'd2, 0, 300,   200,   60000, 0, 0, 16};
      tbl[18] = '{1, 2'd2, 0, 300,   300,   24464, 1, 0, 16};
      tbl[19] = '{1, 2'd3, 0, 65535, 65535, 1,     0, 0, 16};

      repeat (3) @(negedge clk);
      check("rst_out8",   {24'd0, b8.alu_out}, 0);
      check("rst_valid8", {31'd0, b8.alu_valid}, 0);
      check("rst_busy8",  {31'd0, b8.alu_busy}, 0);
      check("rst_ovf8",   {31'd0, b8.alu_ovf}, 0);
      check("rst_dbz8",   {31'd0, b8.alu_div_by_zero}, 0);
      check("rst_out16",  {16'd0, b16.alu_out}, 0);
      reset = 1'b1;

      for (int i = 0; i < NV; i++) run($sformatf("vec%0d", i), tbl[i]);

      // requests pulsed while a MUL runs are dropped; inputs change but the captured operands hold
      @(negedge clk);
      op = 2'd2; cmpm = 1'b0; rs = 7; rt = 6; en8 = 1'b1;
      @(posedge clk);
      v = '{0, 2'd2, 0, 7, 6, 42, 0, 0, 8};
      push(v);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         op = 2'd0; rs = 1; rt = 1; en8 = i[0];
      end
      @(negedge clk);
      en8 = 1'b0;
      n = 6;
      while (!b8.alu_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("busy_drop_latency", n, 8);
      repeat (3) @(negedge clk);

      // single-cycle ops issued every cycle
      op = 2'd0; rs = 3; rt = 4; en8 = 1'b1;
      @(posedge clk);
      v = '{0, 2'd0, 0, 3, 4, 7, 0, 0, 0};
      push(v);
      @(negedge clk);
      op = 2'd1; rs = 9; rt = 4;
      @(posedge clk);
      v = '{0, 2'd1, 0, 9, 4, 5, 0, 0, 0};
      push(v);
      @(negedge clk);
      cmpm = 1'b1; rs = 2; rt = 9;
      @(posedge clk);
      v = '{0, 2'd1, 1, 2, 9, 4, 0, 0, 0};
      push(v);
      @(negedge clk);
      en8 = 1'b0; cmpm = 1'b0;
      repeat (2) @(negedge clk);

      // new request presented during the valid cycle of a DIV is taken at the next edge
      op = 2'd3; rs = 30; rt = 5; en8 = 1'b1;
      @(posedge clk);
      v = '{0, 2'd3, 0, 30, 5, 6, 0, 0, 8};
      push(v);
      #1 en8 = 1'b0;
      n = 0;
      @(negedge clk);
      while (!b8.alu_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("b2b_div_latency", n, 8);
      op = 2'd0; rs = 8; rt = 8; en8 = 1'b1;
      @(posedge clk);
      v = '{0, 2'd0, 0, 8, 8, 16, 0, 0, 0};
      push(v);
      @(negedge clk);
      en8 = 1'b0;
      check("b2b_add_valid", {31'd0, b8.alu_valid}, 1);

      // a running DIV completes even after core_state leaves EXECUTE
      @(negedge clk);
      op = 2'd3; rs = 60000; rt = 7; en16 = 1'b1;
      @(posedge clk);
      v = '{1, 2'd3, 0, 60000, 7, 8571, 0, 0, 16};
      push(v);
      #1 en16 = 1'b0;
      repeat (3) @(negedge clk);
      core_state = 3'b000;
      n = 2;
      while (!b16.alu_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("state_change_latency", n, 16);
      core_state = EXEC;

      // asynchronous reset in the middle of a MUL
      run("div_by_zero_pre_reset", tbl[13]);
      @(negedge clk);
      op = 2'd2; rs = 20; rt = 20; en8 = 1'b1;
      @(posedge clk);
      #1 en8 = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset_busy", {31'd0, b8.alu_busy}, 1);
      #2 reset = 1'b0;
      #1;
      check("async_out8",   {24'd0, b8.alu_out}, 0);
      check("async_valid8", {31'd0, b8.alu_valid}, 0);
      check("async_busy8",  {31'd0, b8.alu_busy}, 0);
      check("async_ovf8",   {31'd0, b8.alu_ovf}, 0);
      check("async_dbz8",   {31'd0, b8.alu_div_by_zero}, 0);
      check("async_out16",  {16'd0, b16.alu_out}, 0);
      @(negedge clk);
      reset = 1'b1;
      v = '{0, 2'd0, 0, 1, 1, 2, 0, 0, 0};
      run("post_reset_add", v);
      repeat (12) @(negedge clk);

      check("pending8",  q8.size(), 0);
      check("pending16", q16.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
